// File: rtl/cpu_mem_bridge_pkg.sv
// Shared types and constants for the CPU-to-RAM/IO memory bridge.
package cpu_mem_bridge_pkg;

  localparam int unsigned IO_SEL_BIT     = 15;
  localparam int unsigned RAM_RD_LATENCY = 1;
  localparam int unsigned LAT_CNT_W      = 2;

  typedef enum logic [2:0] {
    IDLE,
    RAM_RD,
    IO_ACC,
    IO_ACK,
    RESP
  } bridge_state_e;

endpackage

// File: rtl/cpu_mem_bridge_decode.sv
// Combinational target decode: selects RAM or I/O and strips the select bit.
import cpu_mem_bridge_pkg::*;

module mem_addr_decode (
  input  logic [15:0] i_addr,
  output logic        o_is_io,
  output logic [14:0] o_local_addr
);

  assign o_is_io      = i_addr[IO_SEL_BIT];
  assign o_local_addr = i_addr[IO_SEL_BIT-1:0];

endmodule

// File: rtl/cpu_mem_bridge.sv
// Bridges a held-request CPU bus to a synchronous RAM (fast path) and a
// stallable I/O bus (registered, multi-cycle path).
import cpu_mem_bridge_pkg::*;

module cpu_mem_bridge (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_addr,
  input  logic        mem_read,
  input  logic        mem_wr,
  input  logic [15:0] mem_wrdata,
  output logic        mem_wait,
  output logic [15:0] mem_rddata,
  output logic        mem_rddatavalid,
  output logic [14:0] ram_addr,
  output logic        ram_rd,
  output logic        ram_wr,
  output logic [15:0] ram_wrdata,
  input  logic [15:0] ram_rddata,
  output logic [14:0] io_addr,
  output logic        io_read,
  output logic        io_write,
  output logic [15:0] io_wrdata,
  input  logic [15:0] io_rddata,
  input  logic        io_wait
);

  bridge_state_e        r_state;
  bridge_state_e        w_state_next;
  logic [15:0]          r_rddata;
  logic                 r_rddatavalid;
  logic [14:0]          r_io_addr;
  logic [15:0]          r_io_wrdata;
  logic                 r_io_is_wr;
  logic [LAT_CNT_W-1:0] r_lat_cnt;

  logic                 w_is_io;
  logic [14:0]          w_local_addr;
  logic                 w_req;
  logic                 w_load_io;
  logic                 w_cap_ram;
  logic                 w_cap_io;

  mem_addr_decode u_decode (
    .i_addr       (mem_addr),
    .o_is_io      (w_is_io),
    .o_local_addr (w_local_addr)
  );

  assign w_req           = mem_read | mem_wr;
  assign ram_addr        = w_local_addr;
  assign ram_wrdata      = mem_wrdata;
  assign io_addr         = r_io_addr;
  assign io_wrdata       = r_io_wrdata;
  assign mem_rddata      = r_rddata;
  assign mem_rddatavalid = r_rddatavalid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_rddata      <= '0;
      r_rddatavalid <= 1'b0;
      r_io_addr     <= '0;
      r_io_wrdata   <= '0;
      r_io_is_wr    <= 1'b0;
      r_lat_cnt     <= '0;
    end else begin
      r_state       <= w_state_next;
      // Valid is high for exactly the one cycle spent in RESP.
      r_rddatavalid <= (w_state_next == RESP);
      if (w_cap_ram) begin
        r_rddata <= ram_rddata;
      end else if (w_cap_io) begin
        r_rddata <= io_rddata;
      end
      if (w_load_io) begin
        r_io_addr   <= w_local_addr;
        r_io_wrdata <= mem_wrdata;
        r_io_is_wr  <= mem_wr;
      end
      if ((r_state == RAM_RD) && (w_state_next == RAM_RD)) begin
        r_lat_cnt <= r_lat_cnt + 1'b1;
      end else begin
        r_lat_cnt <= '0;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    mem_wait     = 1'b0;
    ram_rd       = 1'b0;
    ram_wr       = 1'b0;
    io_read      = 1'b0;
    io_write     = 1'b0;
    w_load_io    = 1'b0;
    w_cap_ram    = 1'b0;
    w_cap_io     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req) begin
          if (w_is_io) begin
            mem_wait     = 1'b1;
            w_load_io    = 1'b1;
            w_state_next = IO_ACC;
          end else if (mem_wr) begin
            ram_wr = 1'b1;
          end else begin
            ram_rd       = 1'b1;
            w_state_next = RAM_RD;
          end
        end
      end
      RAM_RD: begin
        mem_wait = w_req;
        if (r_lat_cnt == LAT_CNT_W'(RAM_RD_LATENCY - 1)) begin
          w_cap_ram    = 1'b1;
          w_state_next = RESP;
        end
      end
      IO_ACC: begin
        mem_wait = w_req;
        io_read  = ~r_io_is_wr;
        io_write = r_io_is_wr;
        if (!io_wait) begin
          w_cap_io     = ~r_io_is_wr;
          w_state_next = IO_ACK;
        end
      end
      IO_ACK: begin
        w_state_next = r_io_is_wr ? IDLE : RESP;
      end
      RESP: begin
        mem_wait     = w_req;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

endmodule
